// File: rtl/clkdiv_ctrl_if.sv
// Config handshake bundle for the programmable clock-enable divider.
// The sequencer offers a divisor; the divider reports ready and rejections.
interface clkdiv_ctrl_if #(
    parameter int W = 8
);
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready;
    logic         cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clkdiv_ctrl.sv
// Runtime-programmable clock-enable divider.
// New divisors are applied only at a period boundary, so no runt periods.
module clkdiv_ctrl #(
    parameter int W       = 8,
    parameter int DEF_DIV = 2
) (
    input  logic         clkin,
    input  logic         rst_n,
    input  logic         en,
    clkdiv_ctrl_if.slave cfg,
    output logic         clkout,
    output logic         tick,
    output logic [W-1:0] cur_div,
    output logic         busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [W-1:0] count;
    logic [W-1:0] pend_div;
    logic         err_q;
    logic         acc;
    logic         good;
    logic         bad;
    logic         wrap;
    logic         running;

    assign acc  = cfg.cfg_valid & cfg.cfg_ready;
    assign good = acc & (cfg.cfg_div >= W'(2));
    assign bad  = acc & (cfg.cfg_div <  W'(2));
    assign wrap = (count == cur_div - 1'b1);

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (en) state_nx = RUN;
            end
            RUN: begin
                if (good && !wrap)   state_nx = PEND;
                else if (wrap && !en) state_nx = IDLE;
            end
            PEND: begin
                if (wrap) state_nx = en ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A divisor accepted mid-period is parked in pend_div until the wrap.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            count    <= '0;
            cur_div  <= W'(DEF_DIV);
            pend_div <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= bad;
            unique case (state)
                IDLE: begin
                    count <= '0;
                    if (good) cur_div <= cfg.cfg_div;
                end
                RUN: begin
                    count <= wrap ? '0 : count + 1'b1;
                    if (good && wrap)  cur_div  <= cfg.cfg_div;
                    if (good && !wrap) pend_div <= cfg.cfg_div;
                end
                PEND: begin
                    count <= wrap ? '0 : count + 1'b1;
                    if (wrap) cur_div <= pend_div;
                end
                default: count <= '0;
            endcase
        end
    end

    always_comb begin
        running       = (state != IDLE);
        clkout        = running & (count < (cur_div >> 1));
        tick          = running & (count == '0);
        busy          = running;
        cfg.cfg_ready = (state != PEND);
        cfg.cfg_err   = err_q;
    end
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Bench for clkdiv_ctrl: period-queue reference model plus directed
// vectors with hand-computed literal expectations.
module tb_clkdiv_ctrl;
    localparam int W       = 8;
    localparam int DEF_DIV = 2;

    logic         clkin = 1'b0;
    logic         rst_n;
    logic         en;
    logic         clkout;
    logic         tick;
    logic [W-1:0] cur_div;
    logic         busy;

    clkdiv_ctrl_if #(.W(W)) cfg_if ();

    clkdiv_ctrl #(.W(W), .DEF_DIV(DEF_DIV)) dut (
        .clkin   (clkin),
        .rst_n   (rst_n),
        .en      (en),
        .cfg     (cfg_if),
        .clkout  (clkout),
        .tick    (tick),
        .cur_div (cur_div),
        .busy    (busy)
    );

    always #5 clkin = ~clkin;

    int checks = 0;
    int errors = 0;
    bit go = 1'b0;

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", n, got, exp, $time);
        end
    endtask

    // Reference: each period is expanded into a queue of per-cycle
    // {tick, clkout} values; a period ending decides what comes next.
    bit         m_run;
    int         m_cur;
    bit         m_pv;
    int         m_pend;
    bit         m_err;
    logic [1:0] q[$];

    function automatic void push_period(input int d);
        for (int i = 0; i < d; i++) begin
            q.push_back({(i == 0), (i < d / 2)});
        end
    endfunction

    always @(posedge clkin) begin
        bit acc;
        bit good;
        bit last;
        if (!rst_n) begin
            m_run = 0;
            q.delete();
            m_cur = DEF_DIV;
            m_pv  = 0;
            m_err = 0;
        end else begin
            acc   = cfg_if.cfg_valid && !m_pv;
            good  = acc && (int'(cfg_if.cfg_div) >= 2);
            m_err = acc && (int'(cfg_if.cfg_div) < 2);
            if (!m_run) begin
                if (good) m_cur = int'(cfg_if.cfg_div);
                if (en) begin
                    m_run = 1;
                    push_period(m_cur);
                end
            end else begin
                void'(q.pop_front());
                last = (q.size() == 0);
                if (good && last) m_cur = int'(cfg_if.cfg_div);
                if (good && !last) begin
                    m_pv   = 1;
                    m_pend = int'(cfg_if.cfg_div);
                end
                if (last) begin
                    if (m_pv) begin
                        m_cur = m_pend;
                        m_pv  = 0;
                    end
                    if (en) push_period(m_cur);
                    else    m_run = 0;
                end
            end
        end
    end

    always @(negedge clkin) begin
        logic [1:0] e;
        if (go) begin
            e = (m_run && q.size() > 0) ? q[0] : 2'b00;
            chk("m_clkout",  32'(clkout),           32'(e[0]));
            chk("m_tick",    32'(tick),             32'(e[1]));
            chk("m_busy",    32'(busy),             32'(m_run));
            chk("m_cur_div", 32'(cur_div),          32'(m_cur));
            chk("m_ready",   32'(cfg_if.cfg_ready), 32'(!m_pv));
            chk("m_err",     32'(cfg_if.cfg_err),   32'(m_err));
        end
    end

    task automatic step();
        @(negedge clkin);
    endtask

    initial begin
        logic exp5[5];
        exp5 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rst_n = 1'b0;
        en = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div = '0;
        step();
        step();
        go = 1'b1;
        chk("rst_cur_div", 32'(cur_div), 32'd2);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk("rst_clkout", 32'(clkout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        rst_n = 1'b1;
        step();
        en = 1'b1;
        step();
        chk("d2_c0_clk", 32'(clkout), 32'd1);
        chk("d2_c0_tick", 32'(tick), 32'd1);
        step();
        chk("d2_c1_clk", 32'(clkout), 32'd0);
        chk("d2_c1_tick", 32'(tick), 32'd0);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd5;
        // Offered on the wrap cycle: applies immediately.
        for (int k = 0; k < 5; k++) begin
            step();
            chk("d5_clk", 32'(clkout), 32'(exp5[k]));
            if (k == 0) begin
                chk("d5_cur_div", 32'(cur_div), 32'd5);
                chk("d5_ready", 32'(cfg_if.cfg_ready), 32'd1);
                chk("d5_tick", 32'(tick), 32'd1);
                cfg_if.cfg_valid = 1'b0;
            end
            if (k == 4) begin
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_div = 8'd4;
            end
        end
        step();
        chk("d4_cur_div", 32'(cur_div), 32'd4);
        chk("d4_tick", 32'(tick), 32'd1);
        cfg_if.cfg_valid = 1'b0;
        step();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd3;
        step();
        chk("pend_ready_a", 32'(cfg_if.cfg_ready), 32'd0);
        cfg_if.cfg_valid = 1'b0;
        step();
        chk("pend_ready_b", 32'(cfg_if.cfg_ready), 32'd0);
        chk("pend_old_div", 32'(cur_div), 32'd4);
        step();
        chk("d3_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk("d3_cur_div", 32'(cur_div), 32'd3);
        chk("d3_c0_clk", 32'(clkout), 32'd1);
        step();
        chk("d3_c1_clk", 32'(clkout), 32'd0);
        step();
        chk("d3_c2_clk", 32'(clkout), 32'd0);
        step();
        chk("d3_c0b_tick", 32'(tick), 32'd1);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd1;
        step();
        chk("rej_err", 32'(cfg_if.cfg_err), 32'd1);
        chk("rej_ready", 32'(cfg_if.cfg_ready), 32'd1);
        cfg_if.cfg_valid = 1'b0;
        step();
        chk("rej_err_once", 32'(cfg_if.cfg_err), 32'd0);
        chk("rej_cur_div", 32'(cur_div), 32'd3);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd4;
        step();
        chk("stop_cur_div", 32'(cur_div), 32'd4);
        cfg_if.cfg_valid = 1'b0;
        step();
        en = 1'b0;
        step();
        chk("stop_busy_a", 32'(busy), 32'd1);
        step();
        chk("stop_busy_b", 32'(busy), 32'd1);
        step();
        chk("stop_idle_busy", 32'(busy), 32'd0);
        chk("stop_idle_clk", 32'(clkout), 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("idle_tick", 32'(tick), 32'd0);
        end
        en = 1'b1;
        step();
        chk("restart_tick", 32'(tick), 32'd1);
        step();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd7;
        step();
        chk("rp_ready", 32'(cfg_if.cfg_ready), 32'd0);
        cfg_if.cfg_valid = 1'b0;
        rst_n = 1'b0;
        en = 1'b0;
        step();
        chk("rp_cur_div", 32'(cur_div), 32'd2);
        chk("rp_ready1", 32'(cfg_if.cfg_ready), 32'd1);
        chk("rp_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();
        step();
        chk("rp_never_applied", 32'(cur_div), 32'd2);
        en = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd6;
        step();
        chk("idle_en_cfg_div", 32'(cur_div), 32'd6);
        chk("idle_en_cfg_tick", 32'(tick), 32'd1);
        cfg_if.cfg_valid = 1'b0;
        repeat (12) step();
        en = 1'b0;
        repeat (10) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
